// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-access controller: load/store op
// encodings, FSM state encoding, default ack timeout and the alignment rule.
package mem_access_ctrl_pkg;

  localparam int LOADOP_W        = 3;
  localparam int ACK_TIMEOUT_DEF = 255;

  typedef enum logic [LOADOP_W-1:0] {
    LOP_NONE = 3'd0,
    LOP_LB   = 3'd1,
    LOP_LBU  = 3'd2,
    LOP_LH   = 3'd3,
    LOP_LHU  = 3'd4,
    LOP_LW   = 3'd5
  } loadop_e;

  typedef enum logic [1:0] {
    SOP_NONE = 2'b00,
    SOP_SB   = 2'b01,
    SOP_SH   = 2'b10,
    SOP_SW   = 2'b11
  } storeop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A store op takes precedence, so the load kind is only consulted when
  // no store is present.
  function automatic logic misaligned(input logic [1:0]          storeop,
                                      input logic [LOADOP_W-1:0] loadop,
                                      input logic [1:0]          a);
    logic m;
    m = 1'b0;
    if (storeop != SOP_NONE) begin
      if (storeop == SOP_SH)      m = a[0];
      else if (storeop == SOP_SW) m = |a;
    end else if (loadop == LOP_LH || loadop == LOP_LHU) begin
      m = a[0];
    end else if (loadop == LOP_LW) begin
      m = |a;
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_store_align.sv
// store_align: combinational byte-lane steering for stores.
// Ports:
//   storeop  in  2   store kind (SOP_NONE yields read enables: all lanes, zero data)
//   addr     in  2   low address bits selecting the lane(s)
//   data     in  32  register value; low byte/half/word is stored
//   be       out 4   byte enables, bit i = lane i
//   wdata    out 32  store data replicated across lanes
module store_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  storeop,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata
);

  always_comb begin
    be    = 4'b1111;
    wdata = '0;
    case (storeop)
      SOP_SB: begin
        be    = 4'b0001 << addr;
        wdata = {4{data[7:0]}};
      end
      SOP_SH: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data[15:0]}};
      end
      SOP_SW: begin
        be    = 4'b1111;
        wdata = data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage controller turning an EX_MEM load/store into a
// single RAM request/ack handshake, stalling the pipeline while it is open.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ex_valid/loadop/storeop/addr/storedata   instruction in EX_MEM
//   ram_req/we/addr/be/wdata     request to RAM, held until ack or timeout
//   ram_ack, ram_rdata           RAM completion and read word
//   stall_req                    freeze IF..EX_MEM
//   load_data, low_addr          last completed read word and its byte offset
//   load_valid                   one-cycle: read completed (DONE cycle)
//   misalign, bus_err            one-cycle error pulses
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic [LOADOP_W-1:0] ex_loadop,
  input  logic [1:0]          ex_storeop,
  input  logic [31:0]         ex_addr,
  input  logic [31:0]         ex_storedata,
  output logic                ram_req,
  output logic                ram_we,
  output logic [29:0]         ram_addr,
  output logic [3:0]          ram_be,
  output logic [31:0]         ram_wdata,
  input  logic                ram_ack,
  input  logic [31:0]         ram_rdata,
  output logic                stall_req,
  output logic [31:0]         load_data,
  output logic [1:0]          low_addr,
  output logic                load_valid,
  output logic                misalign,
  output logic                bus_err
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pend_low;
  logic             access, mis, timeout;
  logic [3:0]       be;
  logic [31:0]      wdata;

  assign access  = ex_valid && (ex_storeop != SOP_NONE || ex_loadop != LOP_NONE);
  assign mis     = misaligned(ex_storeop, ex_loadop, ex_addr[1:0]);
  // cnt holds the number of BUSY cycles already spent, so the last allowed
  // cycle is the one where cnt == ACK_TIMEOUT-1.
  assign timeout = (cnt == CNT_W'(ACK_TIMEOUT - 1));

  store_align u_align (
    .storeop (ex_storeop),
    .addr    (ex_addr[1:0]),
    .data    (ex_storedata),
    .be      (be),
    .wdata   (wdata)
  );

  always_comb begin
    state_n   = state;
    stall_req = 1'b0;
    case (state)
      ST_IDLE: if (access && !mis) begin
        stall_req = 1'b1;
        state_n   = ST_BUSY;
      end
      ST_BUSY: begin
        stall_req = 1'b1;
        if (ram_ack || timeout) state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pend_low   <= '0;
      ram_req    <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_be     <= '0;
      ram_wdata  <= '0;
      load_data  <= '0;
      low_addr   <= '0;
      load_valid <= 1'b0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_n;
      load_valid <= 1'b0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (access && !mis) begin
            ram_req   <= 1'b1;
            ram_we    <= (ex_storeop != SOP_NONE);
            ram_addr  <= ex_addr[31:2];
            ram_be    <= be;
            ram_wdata <= wdata;
            pend_low  <= ex_addr[1:0];
            cnt       <= '0;
          end else if (access) begin
            misalign  <= 1'b1;
          end
        end
        ST_BUSY: begin
          cnt <= cnt + 1'b1;
          // ack beats a simultaneous timeout
          if (ram_ack) begin
            ram_req <= 1'b0;
            if (!ram_we) begin
              load_data  <= ram_rdata;
              low_addr   <= pend_low;
              load_valid <= 1'b1;
            end
          end else if (timeout) begin
            ram_req <= 1'b0;
            bus_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [2:0]  ex_loadop = '0;
  logic [1:0]  ex_storeop = '0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_storedata = '0;
  logic        ram_req, ram_we;
  logic [29:0] ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic        ram_ack = 1'b0;
  logic [31:0] ram_rdata = '0;
  logic        stall_req;
  logic [31:0] load_data;
  logic [1:0]  low_addr;
  logic        load_valid, misalign, bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state: last completed read word and byte offset
  logic [31:0] m_ld  = '0;
  logic [1:0]  m_low = '0;

  int   req_rises = 0;
  logic req_q = 1'b0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_loadop(ex_loadop), .ex_storeop(ex_storeop),
    .ex_addr(ex_addr), .ex_storedata(ex_storedata),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_be(ram_be),
    .ram_wdata(ram_wdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .stall_req(stall_req), .load_data(load_data), .low_addr(low_addr),
    .load_valid(load_valid), .misalign(misalign), .bus_err(bus_err)
  );

  always @(negedge clk) begin
    if (ram_req && !req_q) req_rises <= req_rises + 1;
    req_q <= ram_req;
  end

  // One access from the pipeline's point of view. Inputs stay held through
  // the DONE cycle so a wrongly re-accepted request shows up at the next call.
  task automatic run_txn(input logic v, input logic [1:0] sop, input logic [2:0] lop,
                         input logic [31:0] addr, input logic [31:0] data,
                         input int ack_at, input logic [31:0] rdata, input string tag);
    int sz;
    logic acc, mis, st, acked;
    logic [3:0] ebe;
    logic [31:0] ewd;
    acc = v && (sop != 2'd0 || lop != 3'd0);
    st  = (sop != 2'd0);
    if (st) sz = (sop == 2'd1) ? 1 : (sop == 2'd2) ? 2 : 4;
    else    sz = (lop == 3'd1 || lop == 3'd2) ? 1 : (lop == 3'd3 || lop == 3'd4) ? 2 : 4;
    mis = acc && ((addr % sz) != 0);
    ebe = 4'hF; ewd = 32'h0;
    if (sop == 2'd1) begin ebe = 4'(1 << (addr % 4)); ewd = (data & 32'hFF) * 32'h01010101; end
    if (sop == 2'd2) begin ebe = 4'(3 << (addr % 4)); ewd = (data & 32'hFFFF) * 32'h00010001; end
    if (sop == 2'd3) ewd = data;

    @(posedge clk); #1;
    ex_valid = v; ex_storeop = sop; ex_loadop = lop; ex_addr = addr; ex_storedata = data;
    ram_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (stall_req !== (acc && !mis)) begin n_fail++; $display("FAIL issue_stall %s: got %b want %b", tag, stall_req, acc && !mis); end
    n_checks++; if (ram_req !== 1'b0) begin n_fail++; $display("FAIL issue_req %s: got %b want 0", tag, ram_req); end
    n_checks++; if ({load_valid, bus_err, misalign} !== 3'b000) begin n_fail++; $display("FAIL issue_pulses %s: got %b want 000", tag, {load_valid, bus_err, misalign}); end

    if (!acc || mis) begin
      @(posedge clk); #1; ex_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (misalign !== mis) begin n_fail++; $display("FAIL misalign %s: got %b want %b", tag, misalign, mis); end
      n_checks++; if (ram_req !== 1'b0) begin n_fail++; $display("FAIL noreq %s: got %b want 0", tag, ram_req); end
      n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL nostall %s: got %b want 0", tag, stall_req); end
      return;
    end

    acked = 1'b0;
    for (int c = 1; c <= TO; c++) begin
      @(posedge clk); #1;
      ram_ack   = (c == ack_at);
      ram_rdata = (c == ack_at) ? rdata : $urandom;
      @(negedge clk);
      n_checks++; if (ram_req !== 1'b1) begin n_fail++; $display("FAIL busy_req %s c%0d: got %b want 1", tag, c, ram_req); end
      n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL busy_stall %s c%0d: got %b want 1", tag, c, stall_req); end
      n_checks++; if (ram_we !== st) begin n_fail++; $display("FAIL busy_we %s: got %b want %b", tag, ram_we, st); end
      n_checks++; if (ram_addr !== addr[31:2]) begin n_fail++; $display("FAIL busy_addr %s: got %h want %h", tag, ram_addr, addr[31:2]); end
      n_checks++; if (ram_be !== ebe) begin n_fail++; $display("FAIL busy_be %s: got %b want %b", tag, ram_be, ebe); end
      n_checks++; if (ram_wdata !== ewd) begin n_fail++; $display("FAIL busy_wdata %s: got %h want %h", tag, ram_wdata, ewd); end
      n_checks++; if ({load_valid, bus_err} !== 2'b00) begin n_fail++; $display("FAIL busy_pulses %s: got %b want 00", tag, {load_valid, bus_err}); end
      if (c == ack_at) begin acked = 1'b1; break; end
    end

    @(posedge clk); #1; ram_ack = 1'b0;
    @(negedge clk);
    if (acked && !st) begin m_ld = rdata; m_low = addr[1:0]; end
    n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL done_stall %s: got %b want 0", tag, stall_req); end
    n_checks++; if (ram_req !== 1'b0) begin n_fail++; $display("FAIL done_req %s: got %b want 0", tag, ram_req); end
    n_checks++; if (bus_err !== !acked) begin n_fail++; $display("FAIL done_buserr %s: got %b want %b", tag, bus_err, !acked); end
    n_checks++; if (load_valid !== (acked && !st)) begin n_fail++; $display("FAIL done_lv %s: got %b want %b", tag, load_valid, acked && !st); end
    n_checks++; if (load_data !== m_ld) begin n_fail++; $display("FAIL done_ld %s: got %h want %h", tag, load_data, m_ld); end
    n_checks++; if (low_addr !== m_low) begin n_fail++; $display("FAIL done_low %s: got %b want %b", tag, low_addr, m_low); end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1; ex_valid = 1'b0; ex_storeop = '0; ex_loadop = '0; ram_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({ram_req, ram_we, ram_addr, ram_be, ram_wdata} !== '0) begin n_fail++; $display("FAIL reset_ram: got %b%b %h %b %h want zeros", ram_req, ram_we, ram_addr, ram_be, ram_wdata); end
    n_checks++; if ({stall_req, load_valid, misalign, bus_err} !== 4'b0) begin n_fail++; $display("FAIL reset_ctl: got %b want 0000", {stall_req, load_valid, misalign, bus_err}); end
    n_checks++; if ({load_data, low_addr} !== '0) begin n_fail++; $display("FAIL reset_ld: got %h %b want 0", load_data, low_addr); end
    @(posedge clk); #1; rst = 1'b0;
    m_ld = '0; m_low = '0;
  endtask

  task automatic test_sb();
    run_txn(1'b1, 2'd1, 3'd0, 32'h103, 32'h000000AB, 2, 32'h0, "sb");
    idle(1);
  endtask

  task automatic test_lw();
    run_txn(1'b1, 2'd0, LOP_LW, 32'h200, 32'h0, 1, 32'hDEADBEEF, "lw");
    idle(1);
  endtask

  task automatic test_misalign();
    run_txn(1'b1, 2'd0, LOP_LH, 32'h201, 32'h0, 1, 32'h0, "lh_mis");
    idle(2);
    n_checks++; if (ram_req !== 1'b0) begin n_fail++; $display("FAIL mis_noreq_later: got %b want 0", ram_req); end
    run_txn(1'b1, 2'd3, 3'd0, 32'h202, 32'h12345678, 1, 32'h0, "sw_mis");
    idle(1);
  endtask

  task automatic test_timeout();
    run_txn(1'b1, 2'd0, LOP_LW, 32'h300, 32'h0, 0, 32'h0, "lw_timeout");
    idle(1);
    // ack in the very last allowed cycle must win over the timeout
    run_txn(1'b1, 2'd0, LOP_LHU, 32'h402, 32'h0, TO, 32'hCAFEF00D, "ack_at_limit");
    idle(1);
  endtask

  task automatic test_reset_busy();
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_storeop = 2'd0; ex_loadop = LOP_LW; ex_addr = 32'h500;
    @(posedge clk); #1;               // BUSY cycle 1
    @(posedge clk); #1; rst = 1'b1;   // BUSY cycle 2
    @(negedge clk);
    n_checks++; if (ram_req !== 1'b1) begin n_fail++; $display("FAIL rstbusy_pre: got %b want 1", ram_req); end
    @(posedge clk); #1; rst = 1'b0; ex_valid = 1'b0; ram_ack = 1'b1; ram_rdata = 32'h0BADF00D;
    m_ld = '0; m_low = '0;
    @(negedge clk);
    n_checks++; if (ram_req !== 1'b0) begin n_fail++; $display("FAIL rstbusy_req: got %b want 0", ram_req); end
    n_checks++; if ({load_valid, bus_err, stall_req} !== 3'b000) begin n_fail++; $display("FAIL rstbusy_ctl: got %b want 000", {load_valid, bus_err, stall_req}); end
    @(posedge clk); #1; ram_ack = 1'b0;
    @(negedge clk);
    n_checks++; if ({load_valid, bus_err, ram_req} !== 3'b000) begin n_fail++; $display("FAIL rstbusy_after: got %b want 000", {load_valid, bus_err, ram_req}); end
    n_checks++; if (load_data !== 32'h0) begin n_fail++; $display("FAIL rstbusy_ld: got %h want 0", load_data); end
    // controller must be back in IDLE and serve a fresh request normally
    run_txn(1'b1, 2'd0, LOP_LB, 32'h503, 32'h0, 2, 32'h11223344, "post_reset");
    idle(1);
  endtask

  task automatic test_ack_ignored();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; ram_ack = 1'b1; ram_rdata = $urandom;
      @(negedge clk);
      n_checks++; if ({load_valid, ram_req} !== 2'b00 || load_data !== m_ld) begin n_fail++; $display("FAIL ack_idle: got lv%b req%b ld %h want 0 0 %h", load_valid, ram_req, load_data, m_ld); end
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = req_rises;
    run_txn(1'b1, 2'd3, 3'd0, 32'h600, 32'hA5A5_5A5A, 3, 32'h0, "b2b_sw");
    run_txn(1'b1, 2'd0, LOP_LB, 32'h601, 32'h0, 1, 32'h7788_99AA, "b2b_lb");
    idle(2);
    n_checks++; if (req_rises - r0 !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", req_rises - r0); end
  endtask

  task automatic test_random();
    logic v;
    logic [1:0] sop;
    logic [2:0] lop;
    for (int i = 0; i < 40; i++) begin
      v   = ($urandom_range(0, 7) != 0);
      sop = ($urandom_range(0, 1) != 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      lop = 3'($urandom_range(0, 5));
      run_txn(v, sop, lop, $urandom, $urandom, int'($urandom_range(0, TO + 1)), $urandom, "rand");
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_sb();
    test_lw();
    test_misalign();
    test_timeout();
    test_reset_busy();
    test_ack_ignored();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
